// File: rtl/grid2048_pkg.sv
// Shared encodings and helpers for the 2048 game core.
package grid2048_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef enum logic [2:0] {
    S_INIT_CLR, S_INIT_SPAWN, S_IDLE, S_MOVE, S_SPAWN, S_CHECK, S_OVER
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/grid2048_line_merge.sv
// Combinational compact/merge of one line; element 0 is the destination edge.
module grid2048_line_merge import grid2048_pkg::*; #(
  parameter int N       = 4,
  parameter int EXP_W   = 4,
  parameter int SCORE_W = 16
) (
  input  logic [N-1:0][EXP_W-1:0] line_i,
  output logic [N-1:0][EXP_W-1:0] line_o,
  output logic [SCORE_W-1:0]      score_inc_o,
  output logic                    changed_o,
  output logic [EXP_W-1:0]        max_exp_o
);
  localparam int KW = $clog2(N + 1);
  localparam logic [EXP_W-1:0] MAXE = '1;

  // cmp/res carry one spare slot so the i+1 look-ahead never leaves the array
  logic [N:0][EXP_W-1:0] cmp, res;
  logic [KW-1:0]         k;
  logic                  skip;
  logic [EXP_W-1:0]      nexp;
  logic [SCORE_W:0]      acc, term;

  // Compact, then merge pairs from the edge outward; a merged tile is skipped
  always_comb begin
    cmp = '0; res = '0; k = '0; skip = 1'b0; nexp = '0;
    acc = '0; term = '0; max_exp_o = '0;
    for (int i = 0; i < N; i++) begin
      if (line_i[i] != '0) begin
        cmp[k] = line_i[i];
        k = k + 1'b1;
      end
    end
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[i] != '0) begin
        if (cmp[i+1] == cmp[i] && cmp[i] != MAXE) begin
          nexp   = cmp[i] + 1'b1;
          res[k] = nexp;
          skip   = 1'b1;
          if (nexp > max_exp_o) max_exp_o = nexp;
          if (int'(nexp) >= SCORE_W) term = {1'b0, {SCORE_W{1'b1}}};
          else                       term = (SCORE_W+1)'(1) << nexp;
          acc = acc + term;
          if (acc[SCORE_W]) acc = {1'b0, {SCORE_W{1'b1}}};
        end else begin
          res[k] = cmp[i];
        end
        k = k + 1'b1;
      end
    end
    line_o      = res[N-1:0];
    score_inc_o = acc[SCORE_W-1:0];
    changed_o   = (res[N-1:0] != line_i);
  end

endmodule

// File: rtl/grid2048_engine.sv
// 2048 core: grid storage, move sequencing, tile spawn and game-over scan.
module grid2048_engine import grid2048_pkg::*; #(
  parameter int          N       = 4,
  parameter int          EXP_W   = 4,
  parameter int          SCORE_W = 16,
  parameter int          WIN_EXP = 11,
  parameter logic [15:0] SEED    = SEED_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      move_valid,
  input  logic [1:0]                move_dir,
  output logic                      move_ready,
  input  logic [$clog2(N*N)-1:0]    rd_idx,
  output logic [EXP_W-1:0]          rd_exp,
  output logic [SCORE_W-1:0]        score,
  output logic                      moved,
  output logic                      won,
  output logic                      game_over
);
  localparam int NN = N * N;
  localparam int CW = $clog2(NN);
  localparam int LW = $clog2(N);

  state_e                      state_q, state_d;
  logic [NN-1:0][EXP_W-1:0]    grid_q, grid_d;
  logic [1:0]                  dir_q, dir_d;
  logic [LW-1:0]               line_q, line_d;
  logic                        chg_q, chg_d, moved_q, moved_d;
  logic                        won_q, won_d, over_q, over_d;
  logic                        alive_q, alive_d, spn_q, spn_d;
  logic [SCORE_W-1:0]          score_q, score_d;
  logic [CW-1:0]               scan_q, scan_d, chk_q, chk_d;
  logic [15:0]                 lfsr_q;

  logic [N-1:0][CW-1:0]        cidx;
  logic [N-1:0][EXP_W-1:0]     ln_in, ln_out;
  logic [SCORE_W-1:0]          ln_inc;
  logic                        ln_chg;
  logic [EXP_W-1:0]            ln_max;
  logic [SCORE_W:0]            sum;
  logic [CW-1:0]               scan_start, scan_nxt;
  logic [EXP_W-1:0]            spawn_val, cur_v;
  logic                        cur_alive, col_last, row_last;

  assign move_ready = (state_q == S_IDLE);
  assign rd_exp     = grid_q[rd_idx];
  assign score      = score_q;
  assign moved      = moved_q;
  assign won        = won_q;
  assign game_over  = over_q;

  assign scan_start = CW'(lfsr_q % NN);
  assign scan_nxt   = (int'(scan_q) == NN-1) ? '0 : scan_q + 1'b1;
  assign spawn_val  = (lfsr_q[3:0] == 4'd0) ? EXP_W'(2) : EXP_W'(1);

  // Gather the current line in order of motion (element 0 = destination edge)
  always_comb begin
    cidx = '0; ln_in = '0;
    for (int e = 0; e < N; e++) begin
      unique case (dir_q)
        DIR_LEFT:  cidx[e] = CW'(int'(line_q) * N + e);
        DIR_RIGHT: cidx[e] = CW'(int'(line_q) * N + (N-1-e));
        DIR_UP:    cidx[e] = CW'(e * N + int'(line_q));
        default:   cidx[e] = CW'((N-1-e) * N + int'(line_q));
      endcase
      ln_in[e] = grid_q[cidx[e]];
    end
  end

  grid2048_line_merge #(.N(N), .EXP_W(EXP_W), .SCORE_W(SCORE_W)) u_merge (
    .line_i(ln_in), .line_o(ln_out), .score_inc_o(ln_inc),
    .changed_o(ln_chg), .max_exp_o(ln_max)
  );

  // Liveness of the scanned cell: empty, or equal to right/lower neighbour
  always_comb begin
    cur_v     = grid_q[chk_q];
    col_last  = (int'(chk_q) % N) == N-1;
    row_last  = int'(chk_q) >= NN-N;
    cur_alive = (cur_v == '0)
             || (!col_last && cur_v == grid_q[CW'(int'(chk_q) + 1)])
             || (!row_last && cur_v == grid_q[CW'(int'(chk_q) + N)]);
  end

  // Next-state and datapath updates for every state
  always_comb begin
    state_d = state_q; grid_d = grid_q; dir_d = dir_q; line_d = line_q;
    chg_d = chg_q; score_d = score_q; moved_d = 1'b0; won_d = won_q;
    over_d = over_q; scan_d = scan_q; chk_d = chk_q; alive_d = alive_q;
    spn_d = spn_q; sum = '0;
    unique case (state_q)
      S_INIT_CLR: begin
        grid_d  = '0;
        scan_d  = scan_start;
        spn_d   = 1'b0;
        state_d = S_INIT_SPAWN;
      end
      S_INIT_SPAWN, S_SPAWN: begin
        if (grid_q[scan_q] == '0) begin
          grid_d[scan_q] = spawn_val;
          if (state_q == S_SPAWN) begin
            chk_d   = '0;
            alive_d = 1'b0;
            state_d = S_CHECK;
          end else if (spn_q) begin
            state_d = S_IDLE;
          end else begin
            spn_d  = 1'b1;
            scan_d = scan_start;
          end
        end else begin
          scan_d = scan_nxt;
        end
      end
      S_IDLE: begin
        if (move_valid) begin
          dir_d   = move_dir;
          line_d  = '0;
          chg_d   = 1'b0;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        for (int e = 0; e < N; e++) grid_d[cidx[e]] = ln_out[e];
        sum     = {1'b0, score_q} + {1'b0, ln_inc};
        score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        if (int'(ln_max) >= WIN_EXP) won_d = 1'b1;
        chg_d = chg_q | ln_chg;
        if (int'(line_q) == N-1) begin
          if (chg_q | ln_chg) begin
            moved_d = 1'b1;
            scan_d  = scan_start;
            state_d = S_SPAWN;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          line_d = line_q + 1'b1;
        end
      end
      S_CHECK: begin
        alive_d = alive_q | cur_alive;
        chk_d   = chk_q + 1'b1;
        if (int'(chk_q) == NN-1) begin
          if (alive_q | cur_alive) begin
            state_d = S_IDLE;
          end else begin
            over_d  = 1'b1;
            state_d = S_OVER;
          end
        end
      end
      S_OVER: ;
      default: state_d = S_INIT_CLR;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT_CLR;
    else     state_q <= state_d;
  end

  // Grid only changes while clearing, moving or spawning
  always_ff @(posedge clk) begin
    if (rst) grid_q <= '0;
    else if (state_q inside {S_INIT_CLR, S_INIT_SPAWN, S_MOVE, S_SPAWN})
      grid_q <= grid_d;
  end

  // Spawn LFSR free-runs every cycle out of reset
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_next(lfsr_q);
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= DIR_LEFT; line_q <= '0; chg_q <= 1'b0; moved_q <= 1'b0;
      won_q <= 1'b0; over_q <= 1'b0; alive_q <= 1'b0; spn_q <= 1'b0;
      score_q <= '0; scan_q <= '0; chk_q <= '0;
    end else begin
      dir_q <= dir_d; line_q <= line_d; chg_q <= chg_d; moved_q <= moved_d;
      won_q <= won_d; over_q <= over_d; alive_q <= alive_d; spn_q <= spn_d;
      score_q <= score_d; scan_q <= scan_d; chk_q <= chk_d;
    end
  end

endmodule

// File: tb/tb_grid2048_engine.sv
// Directed bench for grid2048_engine (N=4, EXP_W=4, default seed).
module tb_grid2048_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        move_ready;
  logic [3:0]  rd_idx = '0;
  logic [3:0]  rd_exp;
  logic [15:0] score;
  logic        moved, won, game_over;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grid2048_engine dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .rd_idx(rd_idx), .rd_exp(rd_exp),
    .score(score), .moved(moved), .won(won), .game_over(game_over)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rd_now(input int i, output logic [3:0] v);
    rd_idx = 4'(i);
    #1;
    v = rd_exp;
  endtask

  // Read 4 consecutive cells within the current low clock phase
  task automatic rd_row(input int base, output logic [15:0] r);
    logic [3:0] v;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      rd_now(base + c, v);
      r[c*4 +: 4] = v;
    end
  endtask

  task automatic count_nz(output int nz, output int bad);
    logic [3:0] v;
    nz = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_now(i, v);
      if (v != 4'd0) nz++;
      if (v > 4'd2) bad++;
    end
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (move_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(move_ready), 32'd1);
  endtask

  // Issue a move; returns at the 5th negedge after setting move_valid
  task automatic run_move(input logic [1:0] d, output logic mv_early, output logic rdy_n4);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = d;
    @(negedge clk);
    move_valid = 1'b0;
    mv_early   = moved;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mv_early = mv_early | moved;
    end
    rdy_n4 = move_ready;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0][3:0] g;
    logic [15:0]      r;
    logic [3:0]       v;
    logic             mv, rdy;
    int               nz, bad, t;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(move_ready), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_flags", {29'd0, moved, won, game_over}, 32'd0);
    count_nz(nz, bad);
    chk("rst_grid_nz", nz, 0);

    // Init spawns exactly two tiles of exponent 1 or 2
    rst = 1'b0;
    wait_ready("init_ready");
    count_nz(nz, bad);
    chk("init_nz", nz, 2);
    chk("init_vals", bad, 0);
    chk("init_score", 32'(score), 32'd0);

    // [1,1,1,1] left -> [2,2,0,0], +8
    g = '0;
    for (int c = 0; c < 4; c++) g[c] = 4'd1;
    dut.grid_q = g;
    run_move(2'd0, mv, rdy);
    chk("m1_early_moved", 32'(mv), 32'd0);
    chk("m1_moved", 32'(moved), 32'd1);
    rd_row(0, r);
    chk("m1_row0", 32'(r), 32'h0022);
    chk("m1_score", 32'(score), 32'd8);
    @(negedge clk);
    chk("m1_moved_once", 32'(moved), 32'd0);
    wait_ready("m1_ready");
    count_nz(nz, bad);
    chk("m1_spawned", nz, 3);

    // [1,0,1,2] right -> [0,0,2,2], +4
    g = '0;
    g[0] = 4'd1; g[2] = 4'd1; g[3] = 4'd2;
    dut.grid_q = g;
    run_move(2'd1, mv, rdy);
    chk("m2_moved", 32'(moved), 32'd1);
    rd_row(0, r);
    chk("m2_row0", 32'(r), 32'h2200);
    chk("m2_score", 32'(score), 32'd12);
    wait_ready("m2_ready");

    // [2,0,0,0] left: no change, back to ready after N+1 cycles, no spawn
    g = '0;
    g[0] = 4'd2;
    dut.grid_q = g;
    run_move(2'd0, mv, rdy);
    chk("m3_ready_n4", 32'(rdy), 32'd0);
    chk("m3_ready_n5", 32'(move_ready), 32'd1);
    chk("m3_no_moved", 32'(mv | moved), 32'd0);
    chk("m3_score", 32'(score), 32'd12);
    count_nz(nz, bad);
    chk("m3_nz", nz, 1);
    @(negedge clk);
    rd_now(0, v);
    chk("m3_cell0", 32'(v), 32'd2);

    // Column 0 [10,10,0,0] up -> 11, won, +2048
    chk("m4_won_before", 32'(won), 32'd0);
    g = '0;
    g[0] = 4'd10; g[4] = 4'd10;
    dut.grid_q = g;
    run_move(2'd2, mv, rdy);
    chk("m4_moved", 32'(moved), 32'd1);
    rd_now(0, v);
    chk("m4_cell0", 32'(v), 32'd11);
    rd_now(4, v);
    chk("m4_cell4", 32'(v), 32'd0);
    chk("m4_won", 32'(won), 32'd1);
    chk("m4_score", 32'(score), 32'd2060);
    wait_ready("m4_ready");

    // Pair at the maximum exponent does not merge
    g = '0;
    g[0] = 4'd15; g[4] = 4'd15;
    dut.grid_q = g;
    run_move(2'd2, mv, rdy);
    chk("m5_no_moved", 32'(mv | moved), 32'd0);
    chk("m5_ready", 32'(move_ready), 32'd1);
    rd_now(0, v);
    chk("m5_cell0", 32'(v), 32'd15);
    rd_now(4, v);
    chk("m5_cell4", 32'(v), 32'd15);
    chk("m5_score", 32'(score), 32'd2060);

    // One merge leaves a single hole; the spawned tile locks the board
    g = '0;
    g[0]=4'd3;  g[1]=4'd3;  g[2]=4'd5;  g[3]=4'd6;
    g[4]=4'd5;  g[5]=4'd6;  g[6]=4'd7;  g[7]=4'd8;
    g[8]=4'd4;  g[9]=4'd5;  g[10]=4'd6; g[11]=4'd7;
    g[12]=4'd5; g[13]=4'd6; g[14]=4'd7; g[15]=4'd8;
    dut.grid_q = g;
    run_move(2'd0, mv, rdy);
    chk("m6_moved", 32'(moved), 32'd1);
    rd_row(0, r);
    chk("m6_row0", 32'(r), 32'h0654);
    chk("m6_score", 32'(score), 32'd2076);
    t = 0;
    while (game_over !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("m6_game_over", 32'(game_over), 32'd1);
    chk("m6_over_ready", 32'(move_ready), 32'd0);
    rd_now(3, v);
    chk("m6_spawn_val", 32'(v == 4'd1 || v == 4'd2), 32'd1);
    rd_now(7, v);
    chk("m6_cell7", 32'(v), 32'd8);

    // OVER ignores move requests
    move_valid = 1'b1;
    move_dir   = 2'd1;
    mv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mv = mv | moved | move_ready;
    end
    move_valid = 1'b0;
    chk("over_ignored", 32'(mv), 32'd0);
    rd_row(0, r);
    chk("over_row0", 32'(r[11:0]), 32'h654);
    chk("over_score", 32'(score), 32'd2076);

    // Synchronous reset leaves OVER and clears everything
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_flags", {29'd0, moved, won, game_over}, 32'd0);
    chk("rst2_score", 32'(score), 32'd0);
    chk("rst2_ready", 32'(move_ready), 32'd0);
    rd_now(0, v);
    chk("rst2_cell0", 32'(v), 32'd0);
    rst = 1'b0;
    wait_ready("rst2_init_ready");
    count_nz(nz, bad);
    chk("rst2_init_nz", nz, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
